// File: rtl/spart_pkg.sv
// Shared SPART definitions: tx state encoding, default framing parameters.
// The receive path uses the same package so both sides agree on framing.
package spart_pkg;
  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;
  localparam int FRAME_BITS     = DATA_BITS_DEF + 2;
  localparam int FRAME_TICKS    = FRAME_BITS * OVERSAMPLE_DEF;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;
endpackage

// File: rtl/spart_transmit.sv
// SPART transmitter: 8N1-style framing paced by an external oversampling tick,
// with a one-byte holding register in front of the shift register.
module spart_transmit
  import spart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 Enable,
  input  logic                 wr,
  input  logic [DATA_BITS-1:0] DATA,
  output logic                 TxD,
  output logic                 TBR,
  output logic                 busy
);
  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  tx_state_t            state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bitc_q, bitc_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 full_q, full_d;
  logic                 txd_q, txd_d;
  logic                 wrap, load;

  assign wrap = Enable && (tick_q == TICK_LAST);
  assign TxD  = txd_q;
  assign TBR  = ~full_q;
  assign busy = (state_q != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bitc_q  <= '0;
      shift_q <= '0;
      hold_q  <= '0;
      full_q  <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bitc_q  <= bitc_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
      txd_q   <= txd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bitc_d  = bitc_q;
    shift_d = shift_q;
    hold_d  = hold_q;
    full_d  = full_q;
    txd_d   = txd_q;
    load    = 1'b0;

    if (state_q != S_IDLE && Enable)
      tick_d = wrap ? '0 : tick_q + 1'b1;

    case (state_q)
      S_IDLE:  if (full_q) load = 1'b1;
      S_START: if (wrap) begin
        state_d = S_DATA;
        bitc_d  = '0;
        txd_d   = shift_q[0];
      end
      S_DATA: if (wrap) begin
        shift_d = shift_q >> 1;
        if (bitc_q == BIT_LAST) begin
          state_d = S_STOP;
          txd_d   = 1'b1;
        end else begin
          bitc_d = bitc_q + 1'b1;
          txd_d  = shift_d[0];
        end
      end
      S_STOP: if (wrap) begin
        // A queued byte starts immediately: no idle bit between frames.
        if (full_q) load = 1'b1;
        else begin
          state_d = S_IDLE;
          txd_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      state_d = S_START;
      shift_d = hold_q;
      tick_d  = '0;
      bitc_d  = '0;
      txd_d   = 1'b0;
      full_d  = 1'b0;
    end else if (wr && !full_q) begin
      hold_d = DATA;
      full_d = 1'b1;
    end
  end
endmodule

// File: tb/tb_spart_transmit.sv
// Bench for spart_transmit: frame-level reference model checked every cycle,
// directed framing scenarios pinned with literals, then randomized traffic.
module tb_spart_transmit;
  import spart_pkg::*;
  localparam int OS = OVERSAMPLE_DEF;
  localparam int DB = DATA_BITS_DEF;
  localparam int FT = FRAME_TICKS;

  logic          clk = 1'b0, rst_n = 1'b1, Enable = 1'b0, wr = 1'b0;
  logic [DB-1:0] DATA = '0;
  logic          TxD, TBR, busy;
  int            tests = 0, fails = 0;
  bit            chk_en = 1'b0;

  spart_transmit #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clk(clk), .rst_n(rst_n), .Enable(Enable), .wr(wr), .DATA(DATA),
    .TxD(TxD), .TBR(TBR), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a count of Enable pulses since it started;
  // the line level follows from which bit slot that count falls in.
  bit            m_act, m_full, fpre;
  int            m_p;
  logic [DB-1:0] m_byte, m_hold;

  function automatic logic lvl(input logic [DB-1:0] b, input int p);
    int idx;
    idx = p / OS;
    if (idx == 0) return 1'b0;
    if (idx <= DB) return b[idx-1];
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = 1'b0; m_full = 1'b0; m_p = 0;
    end else begin
      fpre = m_full;
      if (!m_act) begin
        if (fpre) begin m_act = 1'b1; m_byte = m_hold; m_p = 0; m_full = 1'b0; end
      end else if (Enable) begin
        m_p++;
        if (m_p == FT) begin
          if (fpre) begin m_byte = m_hold; m_p = 0; m_full = 1'b0; end
          else begin m_act = 1'b0; m_p = 0; end
        end
      end
      if (wr && !fpre) begin m_hold = DATA; m_full = 1'b1; end
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("model_txd", TxD, m_act ? lvl(m_byte, m_p) : 1'b1);
    chk("model_busy", busy, m_act);
    chk("model_tbr", TBR, !m_full);
  end

  logic cap_txd [0:799];
  logic cap_busy[0:799];
  logic cap_tbr [0:799];

  task automatic cyc(input bit en, input bit w, input logic [DB-1:0] d);
    @(negedge clk); #1;
    Enable = en; wr = w; DATA = d;
  endtask

  // Sample i holds the outputs after the edge that consumed inputs of step i.
  task automatic capture(input int n, input int per,
                         input int w0, input logic [DB-1:0] d0,
                         input int w1, input logic [DB-1:0] d1,
                         input int w2, input logic [DB-1:0] d2);
    for (int i = 0; i < n; i++) begin
      if (i == w0)      cyc(i % per == 0, 1'b1, d0);
      else if (i == w1) cyc(i % per == 0, 1'b1, d1);
      else if (i == w2) cyc(i % per == 0, 1'b1, d2);
      else              cyc(i % per == 0, 1'b0, '0);
      @(posedge clk); #1;
      cap_txd[i] = TxD; cap_busy[i] = busy; cap_tbr[i] = TBR;
    end
  endtask

  function automatic logic [DB-1:0] dec(input int s, input int f);
    logic [DB-1:0] b;
    for (int k = 0; k < DB; k++) b[k] = cap_txd[s + f*FT + (k+1)*OS + OS/2];
    return b;
  endfunction

  function automatic int cnt_busy(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (cap_busy[i]) c++;
    return c;
  endfunction

  int exp_a5 [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
  int trans [$];

  initial begin
    int nm, first, last, c;
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_txd", TxD, 1); chk("reset_tbr", TBR, 1); chk("reset_busy", busy, 0);
    rst_n = 1'b1;

    // Single frame 0xA5 with Enable every cycle.
    capture(200, 1, 0, 8'hA5, -1, '0, -1, '0);
    first = -1;
    for (int i = 0; i < 200; i++) if (cap_busy[i] && first < 0) first = i;
    chk("a5_latency", first, 1);
    chk("a5_busy_cycles", cnt_busy(200), 160);
    c = 0;
    for (int i = 0; i < 200; i++) if (!cap_tbr[i]) c++;
    chk("a5_tbr_low", c, 1);
    for (int k = 0; k < 10; k++) begin
      nm = 0;
      for (int j = 0; j < OS; j++) if (cap_txd[1 + k*OS + j] === 1'(exp_a5[k])) nm++;
      chk($sformatf("a5_bit%0d", k), nm, OS);
    end
    nm = 0;
    for (int i = 161; i < 200; i++) if (cap_txd[i] === 1'b1) nm++;
    chk("a5_idle_after", nm, 39);

    // Back-to-back: second byte written while the first is in its data bits.
    capture(400, 1, 0, 8'h3C, 60, 8'hC3, -1, '0);
    last = 0;
    for (int i = 0; i < 400; i++) if (cap_busy[i]) last = i;
    chk("b2b_busy_cycles", cnt_busy(400), 320);
    chk("b2b_busy_last", last, 320);
    chk("b2b_frame0", dec(1, 0), 8'h3C);
    chk("b2b_frame1", dec(1, 1), 8'hC3);

    // Third write while holding is full is dropped.
    capture(400, 1, 0, 8'h11, 3, 8'h22, 5, 8'h33);
    chk("drop_tbr_at_wr", cap_tbr[5], 0);
    chk("drop_frame0", dec(1, 0), 8'h11);
    chk("drop_frame1", dec(1, 1), 8'h22);
    chk("drop_busy_cycles", cnt_busy(400), 320);

    // Enable one cycle in four: bit boundaries 64 clocks apart.
    capture(720, 4, 0, 8'h55, -1, '0, -1, '0);
    trans.delete();
    for (int i = 1; i < 720; i++) if (cap_txd[i] !== cap_txd[i-1]) trans.push_back(i);
    chk("slow_transitions", trans.size(), 10);
    for (int j = 1; j + 1 < trans.size(); j++)
      chk($sformatf("slow_bit_len%0d", j), trans[j+1] - trans[j], 64);

    // Reset in the middle of data bit 3 of 0xFF.
    capture(70, 1, 0, 8'hFF, -1, '0, -1, '0);
    chk("rst_mid_busy_before", cap_busy[69], 1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_txd", TxD, 1); chk("rst_mid_tbr", TBR, 1); chk("rst_mid_busy", busy, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    capture(200, 1, -1, '0, -1, '0, -1, '0);
    chk("rst_after_busy", cnt_busy(200), 0);
    nm = 0;
    for (int i = 0; i < 200; i++) if (cap_txd[i] !== 1'b1) nm++;
    chk("rst_after_txd_low", nm, 0);

    // Randomized traffic; the per-cycle model compare does the checking.
    for (int seg = 0; seg < 16; seg++) begin
      int per;
      per = $urandom_range(1, 4);
      for (int i = 0; i < 500; i++) begin
        cyc($urandom_range(0, per - 1) == 0, $urandom_range(0, 39) == 0, DB'($urandom));
        if ((seg == 8 && i == 250) || $urandom_range(0, 1999) == 0) begin
          @(negedge clk); #2 rst_n = 1'b0;
          @(negedge clk); #1 rst_n = 1'b1;
        end
      end
    end

    cyc(1'b0, 1'b0, '0);
    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
